// File: rtl/mul_div_unit.sv
// mul_div_unit: RV32M iterative multiply/divide, 32 iterations per op.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise ops 1xx complete immediately with 0.
module mul_div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [1:0]  r_op;
    logic        r_neg;
    logic [31:0] r_hi, r_lo, r_b, r_result;

    logic        w_accept, w_skip, w_a_neg, w_b_neg, w_neg;
    logic [31:0] w_a_mag, w_b_mag, w_hi_n, w_lo_n, w_res, w_mul_hi, w_mul_lo, w_mul_res;
    logic [32:0] w_sum;
    logic [63:0] w_prod, w_sprod;

    assign w_accept = start && (r_state != S_RUN);
    assign w_a_neg  = a[31] && (op[2] ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10));
    assign w_b_neg  = b[31] && (op[2] ? ~op[0] : (op[1:0] == 2'b01));
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;
    // remainder takes the dividend's sign; everything else the XOR of both
    assign w_neg    = (op[2] && op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    // shift-add step: r_lo holds the multiplier and shifts out as product bits fill in
    assign w_sum     = {1'b0, r_hi} + {1'b0, r_lo[0] ? r_b : 32'd0};
    assign w_mul_hi  = w_sum[32:1];
    assign w_mul_lo  = {w_sum[0], r_lo[31:1]};
    assign w_prod    = {w_mul_hi, w_mul_lo};
    assign w_sprod   = r_neg ? -w_prod : w_prod;
    assign w_mul_res = (r_op == 2'b00) ? w_sprod[31:0] : w_sprod[63:32];

`ifdef MULDIV_DIV_EN
    logic        r_div, r_dz;
    logic [32:0] w_sh;
    logic [31:0] w_diff, w_div_hi, w_div_lo, w_q, w_r;
    logic        w_ge;

    assign w_sh     = {r_hi, r_lo[31]};
    assign w_ge     = w_sh[32] || (w_sh[31:0] >= r_b);
    assign w_diff   = w_sh[31:0] - r_b;
    assign w_div_hi = w_ge ? w_diff : w_sh[31:0];
    assign w_div_lo = {r_lo[30:0], w_ge};
    assign w_q      = r_dz ? 32'hFFFF_FFFF : (r_neg ? -w_div_lo : w_div_lo);
    assign w_r      = r_neg ? -w_div_hi : w_div_hi;
    assign w_hi_n   = r_div ? w_div_hi : w_mul_hi;
    assign w_lo_n   = r_div ? w_div_lo : w_mul_lo;
    assign w_res    = r_div ? (r_op[1] ? w_r : w_q) : w_mul_res;
    assign w_skip   = 1'b0;
`else
    assign w_hi_n   = w_mul_hi;
    assign w_lo_n   = w_mul_lo;
    assign w_res    = w_mul_res;
    assign w_skip   = op[2];
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_op     <= 2'd0;
            r_neg    <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_b      <= 32'd0;
            r_result <= 32'd0;
`ifdef MULDIV_DIV_EN
            r_div    <= 1'b0;
            r_dz     <= 1'b0;
`endif
        end else if (w_accept) begin
            r_state <= w_skip ? S_DONE : S_RUN;
            r_cnt   <= 5'd0;
            r_op    <= op[1:0];
            r_neg   <= w_neg;
            r_hi    <= 32'd0;
            r_lo    <= w_a_mag;
            r_b     <= w_b_mag;
            if (w_skip)
                r_result <= 32'd0;
`ifdef MULDIV_DIV_EN
            r_div   <= op[2];
            r_dz    <= (b == 32'd0);
`endif
        end else if (r_state == S_RUN) begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
                r_state  <= S_DONE;
                r_result <= w_res;
            end
        end else if (r_state == S_DONE) begin
            r_state <= S_IDLE;
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and random RV32M ops against an arithmetic reference model.
module tb_mul_div_unit;
    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0, b = 32'd0;
    logic        busy, done;
    logic [31:0] result;
    int          n_checks = 0;
    int          n_fail = 0;

    mul_div_unit dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        longint      ux = longint'({32'd0, x});
        longint      uy = longint'({32'd0, y});
        logic [63:0] p;
        case (o)
            MUL:    begin p = ux * uy; return p[31:0];  end
            MULH:   begin p = sx * sy; return p[63:32]; end
            MULHSU: begin p = sx * uy; return p[63:32]; end
            MULHU:  begin p = ux * uy; return p[63:32]; end
`ifdef MULDIV_DIV_EN
            DIV:    begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sx / sy; return p[31:0];
            end
            REM:    begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                p = sx % sy; return p[31:0];
            end
            DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
            REMU:   return (y == 0) ? x : x % y;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] o);
`ifdef MULDIV_DIV_EN
        return 33;
`else
        return o[2] ? 1 : 33;
`endif
    endfunction

    // called at a negedge with the DUT idle or in DONE; returns at the negedge where done is seen
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input bit inj);
        int lat = latency(o);
        int c = 0;
        bit ok = 1'b1;
        bit seen = 1'b0;
        string tag = $sformatf("op%0d_%h_%h", o, x, y);
        start = 1'b1; op = o; a = x; b = y;
        while (!seen && c < 40) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
            end
            if (inj && c == 5) begin
                start = 1'b1; op = MUL; a = 32'd9; b = 32'd9;
            end
            if (inj && c == 6) start = 1'b0;
            if (busy !== (c < lat) || (busy && done)) ok = 1'b0;
            if (done) seen = 1'b1;
        end
        chk({tag, "_busy"}, 32'(ok), 32'd1);
        chk({tag, "_done_cycle"}, c, lat);
        chk({tag, "_result"}, result, exp);
    endtask

    task automatic idle_hold(input int n);
        logic [31:0] held = result;
        for (int i = 0; i < n; i++) @(negedge clk);
        if (n > 0) chk("result_hold", result, held);
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] x, y;
        bit          rst_ok;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        resetn = 1'b1;

        do_op(MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        idle_hold(2);
        do_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        do_op(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        do_op(MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0);
`ifdef MULDIV_DIV_EN
        do_op(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        do_op(REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        do_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        do_op(DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b0);
        do_op(REMU, 32'd100, 32'd0, 32'd100, 1'b0);
        do_op(DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b0);
        do_op(REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b0);
`else
        do_op(DIVU, 32'd10, 32'd2, 32'd0, 1'b0);
        do_op(REM, 32'd10, 32'd3, 32'd0, 1'b0);
`endif
        idle_hold(1);

        // a start during RUN must be ignored; the next start lands on the DONE cycle
        do_op(MUL, 32'd3, 32'd5, 32'd15, 1'b1);
        do_op(MUL, 32'd9, 32'd9, 32'd81, 1'b0);

        start = 1'b1; op = MULHU; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_result", result, 32'd0);
        rst_ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (busy || done) rst_ok = 1'b0;
        end
        chk("midrst_quiet", 32'(rst_ok), 32'd1);
        resetn = 1'b1;
        do_op(MUL, 32'd6, 32'd7, 32'd42, 1'b0);

        for (int i = 0; i < 200; i++) begin
            o = 3'($urandom);
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = 32'($urandom_range(1, 15));
                3: x = 32'hFFFF_FFFF;
                default: ;
            endcase
            do_op(o, x, y, model(o, x, y), 1'b0);
            idle_hold($urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
